// File: rtl/imem_pkg.sv
// imem_pkg: shared state type and size constants for the program-memory arbiter.
package imem_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } imem_state_e;

    localparam int IMEM_ADDR_W     = 14;
    localparam int IMEM_DATA_W     = 32;
    localparam int IMEM_BYTE_OFF_W = 2;   // byte-offset bits below a word address
    localparam int IMEM_CSUM_W     = 32;

endpackage

// File: rtl/imem_load_csum.sv
// imem_load_csum: modulo-2^32 accumulator of loader write data, cleared per load session.
module imem_load_csum
    import imem_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic [IMEM_CSUM_W-1:0] data,
    output logic [IMEM_CSUM_W-1:0] sum
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port program memory between instruction fetch (RUN) and the
// UART loader (LOAD). Define IMEM_LOAD_CHECKSUM_EN to add a load checksum that qualifies load_done.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_mode,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_fault,
    input  logic              l_req,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   load_cnt
`ifdef IMEM_LOAD_CHECKSUM_EN
    ,
    input  logic [31:0]       csum_expect,
    output logic [31:0]       load_csum,
    output logic              load_csum_ok
`endif
);

    // state | meaning: RUN fetch owns memory | DRAIN read in flight | LOAD loader owns memory
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    imem_state_e state, state_n;
    logic        rd_pending;
    logic        done_pulse;
    logic        done_set;
    logic        sess_start;
    logic        f_bad;

    assign f_bad = (f_addr[IMEM_BYTE_OFF_W-1:0] != '0) ||
                   (f_addr[31:ADDR_W+IMEM_BYTE_OFF_W] != '0);

    // A 1-cycle memory returns the last granted read in the cycle RUN first sees load_mode,
    // so the drain completes inside RUN and DRAIN only serves as a safe pass-through.
    always_comb begin
        state_n    = state;
        f_gnt      = 1'b0;
        l_gnt      = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_hold   = 1'b0;
        sess_start = 1'b0;
        done_set   = 1'b0;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    cpu_hold = load_mode;
                    f_gnt    = f_req & ~load_mode;
                    if (f_gnt && !f_bad) begin
                        mem_en   = 1'b1;
                        mem_addr = f_addr[ADDR_W+IMEM_BYTE_OFF_W-1:IMEM_BYTE_OFF_W];
                    end
                    if (load_mode) begin
                        state_n    = LOAD;
                        sess_start = 1'b1;
                    end
                end
                DRAIN: begin
                    cpu_hold   = 1'b1;
                    state_n    = LOAD;
                    sess_start = 1'b1;
                end
                LOAD: begin
                    cpu_hold = 1'b1;
                    l_gnt    = l_req;
                    if (l_req) begin
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = l_addr;
                        mem_wdata = l_wdata;
                    end
                    if (!load_mode) begin
                        state_n  = RUN;
                        done_set = 1'b1;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            rd_pending <= 1'b0;
            f_rvalid   <= 1'b0;
            f_fault    <= 1'b0;
            done_pulse <= 1'b0;
            load_cnt   <= '0;
        end else begin
            state      <= state_n;
            f_rvalid   <= f_gnt;
            f_fault    <= f_gnt & f_bad;
            rd_pending <= f_gnt & ~f_bad;
            done_pulse <= done_set;
            if (sess_start) begin
                load_cnt <= '0;
            end else if (l_gnt && (load_cnt != CNT_MAX)) begin
                load_cnt <= load_cnt + (ADDR_W+1)'(1);
            end
        end
    end

    assign f_rdata = rd_pending ? mem_rdata : '0;

`ifdef IMEM_LOAD_CHECKSUM_EN
    imem_load_csum u_load_csum (
        .clk  (clk),
        .rst  (rst),
        .clr  (sess_start),
        .en   (l_gnt),
        .data (32'(l_wdata)),
        .sum  (load_csum)
    );

    assign load_csum_ok = (load_csum == csum_expect);
    assign load_done    = done_pulse & load_csum_ok;
`else
    assign load_done = done_pulse;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed vectors, hand sequences and a randomized run against a behavioural model.
module tb_imem_arbiter;
    import imem_pkg::*;

    localparam int AW      = IMEM_ADDR_W;
    localparam int DW      = IMEM_DATA_W;
    localparam int DEPTH   = 1 << AW;
    localparam int CNT_SAT = 1 << AW;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          load_mode = 1'b0;
    logic          f_req     = 1'b0;
    logic [31:0]   f_addr    = '0;
    logic          l_req     = 1'b0;
    logic [AW-1:0] l_addr    = '0;
    logic [DW-1:0] l_wdata   = '0;
    logic          f_gnt, f_rvalid, f_fault, l_gnt, mem_en, mem_we, cpu_hold, load_done;
    logic [DW-1:0] f_rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_addr;
    logic [AW:0]   load_cnt;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0]   csum_expect = '0;
    logic [31:0]   load_csum;
    logic          load_csum_ok;
`endif

    int total = 0;
    int bad   = 0;

    imem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .load_mode (load_mode),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .f_fault   (f_fault),
        .l_req     (l_req),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_gnt     (l_gnt),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
`ifdef IMEM_LOAD_CHECKSUM_EN
        .csum_expect  (csum_expect),
        .load_csum    (load_csum),
        .load_csum_ok (load_csum_ok),
`endif
        .load_cnt  (load_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 0) return 32'h11;
        if (i == 1) return 32'h22;
        if (i == 2) return 32'h33;
        if (i == DEPTH - 1) return 32'hCAFE_3FFF;
        return 32'hA500_0000 | 32'(i);
    endfunction

    // Program memory model: 1-cycle synchronous read, preloaded while do_init is high.
    logic          do_init = 1'b1;
    logic [DW-1:0] mem     [0:DEPTH-1];
    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    logic [DW-1:0] ref_mem [0:DEPTH-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        f_req;
        logic [31:0] f_addr;
        logic        l_req;
        logic        e_gnt;
        logic        e_men;
        logic        e_fault;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [8];

    // reference-model state for the randomized run
    bit          m_loading, m_done, m_rv, m_rf;
    int          m_cnt;
    logic [31:0] m_rd, m_sum;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time %0t reached without finish, expected finish earlier", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] s;
        logic        e_f, e_bad, e_l, e_en;
        logic [AW-1:0] e_addr;
        int          word, r;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

        vecs[0] = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h11};
        vecs[1] = '{1'b1, 32'h0000_0006, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[2] = '{1'b1, 32'h0001_0000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[3] = '{1'b1, 32'h0000_FFFC, 1'b0, 1'b1, 1'b1, 1'b0, 32'hCAFE_3FFF};
        vecs[4] = '{1'b0, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 32'h8000_0008, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[6] = '{1'b1, 32'h0000_0008, 1'b1, 1'b1, 1'b1, 1'b0, 32'h33};
        vecs[7] = '{1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};

        // reset: outputs quiet even with every request raised
        load_mode = 1'b1; f_req = 1'b1; l_req = 1'b1; f_addr = '0;
        @(posedge clk); #1; do_init = 1'b0; #1;
        chk("rst_f_gnt", f_gnt, 0);
        chk("rst_l_gnt", l_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_f_rvalid", f_rvalid, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_load_cnt", load_cnt, 0);
        #3; load_mode = 1'b0; f_req = 1'b0; l_req = 1'b0; rst = 1'b0;

        // table vectors in RUN: grant cycle, then response cycle
        for (int i = 0; i < 8; i++) begin
            tick();
            f_req = vecs[i].f_req; f_addr = vecs[i].f_addr; l_req = vecs[i].l_req;
            l_addr = AW'(i); l_wdata = 32'hDEAD_0000 + 32'(i);
            #1;
            chk($sformatf("vec%0d_f_gnt", i), f_gnt, vecs[i].e_gnt);
            chk($sformatf("vec%0d_mem_en", i), mem_en, vecs[i].e_men);
            chk($sformatf("vec%0d_l_gnt", i), l_gnt, 0);
            chk($sformatf("vec%0d_mem_we", i), mem_we, 0);
            tick(); f_req = 1'b0; l_req = 1'b0; #1;
            chk($sformatf("vec%0d_f_rvalid", i), f_rvalid, vecs[i].e_gnt);
            chk($sformatf("vec%0d_f_fault", i), f_fault, vecs[i].e_fault);
            chk($sformatf("vec%0d_f_rdata", i), f_rdata, vecs[i].e_rdata);
        end

        // back-to-back fetches 0,4,8
        tick(); f_req = 1'b1; f_addr = 32'h0; #1;
        chk("b2b_gnt0", f_gnt, 1);
        tick(); f_addr = 32'h4; #1;
        chk("b2b_gnt1", f_gnt, 1); chk("b2b_rv0", f_rvalid, 1); chk("b2b_rd0", f_rdata, 32'h11);
        tick(); f_addr = 32'h8; #1;
        chk("b2b_gnt2", f_gnt, 1); chk("b2b_rv1", f_rvalid, 1); chk("b2b_rd1", f_rdata, 32'h22);
        tick(); f_req = 1'b0; #1;
        chk("b2b_rv2", f_rvalid, 1); chk("b2b_rd2", f_rdata, 32'h33); chk("b2b_flt2", f_fault, 0);

        // fetch at N, load_mode at N+1, then a 5-word load session
        tick(); f_req = 1'b1; f_addr = 32'h4; #1;
        chk("drn_gnt", f_gnt, 1);
        tick(); load_mode = 1'b1; f_addr = 32'h8; #1;
        chk("drn_no_gnt", f_gnt, 0); chk("drn_rv", f_rvalid, 1);
        chk("drn_rd", f_rdata, 32'h22); chk("drn_hold", cpu_hold, 1);
        s = '0;
        for (int k = 0; k < 5; k++) begin
            tick(); l_req = 1'b1; l_addr = AW'(k); l_wdata = 32'hD000_0000 + 32'(k); #1;
            chk($sformatf("ld%0d_l_gnt", k), l_gnt, 1);
            chk($sformatf("ld%0d_mem_we", k), mem_we, 1);
            chk($sformatf("ld%0d_mem_addr", k), mem_addr, k);
            chk($sformatf("ld%0d_mem_wdata", k), mem_wdata, l_wdata);
            chk($sformatf("ld%0d_cnt", k), load_cnt, k);
            chk($sformatf("ld%0d_f_gnt", k), f_gnt, 0);
            if (k == 0) chk("ld0_f_rvalid", f_rvalid, 0);
            ref_mem[k] = l_wdata; s = s + l_wdata;
        end
        tick(); l_req = 1'b0; load_mode = 1'b0; f_req = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
        csum_expect = s;
`endif
        #1;
        chk("ldx_cnt", load_cnt, 5); chk("ldx_hold", cpu_hold, 1); chk("ldx_done", load_done, 0);
        tick(); #1;
        chk("ldd_done", load_done, 1); chk("ldd_hold", cpu_hold, 0); chk("ldd_cnt", load_cnt, 5);
        tick(); #1;
        chk("ldd_done_once", load_done, 0);
        for (int k = 0; k < 6; k++) begin
            tick(); f_req = (k < 5); f_addr = 32'(4 * k); #1;
            if (k > 0) begin
                chk($sformatf("rb%0d_rv", k - 1), f_rvalid, 1);
                chk($sformatf("rb%0d_rd", k - 1), f_rdata, 32'hD000_0000 + 32'(k - 1));
            end
        end

        // single-cycle load_mode pulse still runs a whole (empty) session
        tick(); f_req = 1'b1; f_addr = 32'h0; load_mode = 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
        csum_expect = '0;
`endif
        #1;
        chk("pls_gnt0", f_gnt, 0); chk("pls_hold0", cpu_hold, 1); chk("pls_cnt_held", load_cnt, 5);
        tick(); load_mode = 1'b0; #1;
        chk("pls_gnt1", f_gnt, 0); chk("pls_hold1", cpu_hold, 1); chk("pls_cnt_clr", load_cnt, 0);
        tick(); #1;
        chk("pls_done", load_done, 1); chk("pls_hold2", cpu_hold, 0); chk("pls_gnt2", f_gnt, 1);
        tick(); f_req = 1'b0; #1;
        chk("pls_done_once", load_done, 0); chk("pls_rd", f_rdata, 32'hD000_0000);

        // reset in the middle of a load session
        tick(); load_mode = 1'b1; #1;
        tick(); l_req = 1'b1; l_addr = AW'(7); l_wdata = 32'h7777_0007; #1;
        chk("rml_l_gnt", l_gnt, 1); ref_mem[7] = l_wdata;
        tick(); l_req = 1'b0; #1;
        chk("rml_cnt1", load_cnt, 1);
        #1; rst = 1'b1; l_req = 1'b1; #1;
        chk("rml_hold", cpu_hold, 0); chk("rml_cnt", load_cnt, 0);
        chk("rml_l_gnt0", l_gnt, 0); chk("rml_mem_en", mem_en, 0);
        load_mode = 1'b0; l_req = 1'b0; #2; rst = 1'b0;
        tick(); f_req = 1'b1; f_addr = 32'h1C; #1;
        chk("rml_no_done", load_done, 0); chk("rml_hold_run", cpu_hold, 0); chk("rml_f_gnt", f_gnt, 1);
        tick(); f_req = 1'b0; #1;
        chk("rml_rd", f_rdata, 32'h7777_0007); chk("rml_no_done2", load_done, 0);

`ifdef IMEM_LOAD_CHECKSUM_EN
        tick(); load_mode = 1'b1; #1;
        tick(); l_req = 1'b1; l_addr = AW'(20); l_wdata = 32'hFFFF_FFFF; #1;
        ref_mem[20] = l_wdata;
        tick(); l_addr = AW'(21); l_wdata = 32'h2; #1;
        ref_mem[21] = l_wdata;
        tick(); l_req = 1'b0; load_mode = 1'b0; csum_expect = 32'h1; #1;
        chk("cs_sum", load_csum, 32'h1); chk("cs_ok", load_csum_ok, 1);
        tick(); #1;
        chk("cs_done", load_done, 1); chk("cs_sum_held", load_csum, 32'h1);
`endif

        // load_cnt saturation at 2^ADDR_W
        tick(); load_mode = 1'b1; #1;
        for (int k = 0; k < CNT_SAT + 6; k++) begin
            tick(); l_req = 1'b1; l_addr = AW'(k); l_wdata = 32'h5A5A_0000 ^ 32'(k); #1;
            ref_mem[k % DEPTH] = l_wdata;
            if (k == CNT_SAT - 1) chk("sat_below", load_cnt, CNT_SAT - 1);
        end
        tick(); l_req = 1'b0; #1;
        chk("sat_cnt", load_cnt, CNT_SAT);
        load_mode = 1'b0; #1; rst = 1'b1; #2; rst = 1'b0;

        // randomized run against the behavioural model
        m_loading = 0; m_done = 0; m_rv = 0; m_rf = 0; m_cnt = 0; m_rd = '0; m_sum = '0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if ($urandom_range(9) == 0) load_mode = ~load_mode;
            f_req = 1'($urandom_range(1));
            r = int'($urandom_range(9));
            if (r == 0)      f_addr = $urandom;
            else if (r == 1) f_addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
            else             f_addr = 32'($urandom_range(0, 31) * 4);
            l_req   = 1'($urandom_range(1));
            l_addr  = AW'($urandom_range(0, 31));
            l_wdata = $urandom;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum_expect = ($urandom_range(3) == 0) ? $urandom : m_sum;
`endif
            #1;
            word   = int'((f_addr >> 2) % DEPTH);
            e_f    = f_req && !load_mode && !m_loading;
            e_bad  = (f_addr % 4 != 0) || (f_addr >= 32'(DEPTH * 4));
            e_l    = m_loading && l_req;
            e_en   = e_l || (e_f && !e_bad);
            e_addr = e_l ? l_addr : (e_en ? AW'(word) : '0);
            chk("rnd_f_gnt", f_gnt, e_f);
            chk("rnd_l_gnt", l_gnt, e_l);
            chk("rnd_cpu_hold", cpu_hold, m_loading || load_mode);
            chk("rnd_mem_en", mem_en, e_en);
            chk("rnd_mem_we", mem_we, e_l);
            chk("rnd_mem_addr", mem_addr, e_addr);
            chk("rnd_mem_wdata", mem_wdata, e_l ? l_wdata : '0);
            chk("rnd_f_rvalid", f_rvalid, m_rv);
            chk("rnd_f_fault", f_fault, m_rv && m_rf);
            chk("rnd_f_rdata", f_rdata, (m_rv && !m_rf) ? m_rd : '0);
            chk("rnd_load_cnt", load_cnt, m_cnt);
`ifdef IMEM_LOAD_CHECKSUM_EN
            chk("rnd_load_csum", load_csum, m_sum);
            chk("rnd_csum_ok", load_csum_ok, m_sum == csum_expect);
            chk("rnd_load_done", load_done, m_done && (m_sum == csum_expect));
`else
            chk("rnd_load_done", load_done, m_done);
`endif
            m_rv   = e_f;
            m_rf   = e_bad;
            m_rd   = ref_mem[word];
            m_done = m_loading && !load_mode;
            if (e_l) begin
                ref_mem[l_addr] = l_wdata;
                if (m_cnt < CNT_SAT) m_cnt++;
                m_sum = m_sum + l_wdata;
            end
            if (!m_loading && load_mode) begin
                m_loading = 1; m_cnt = 0; m_sum = '0;
            end else if (m_loading && !load_mode) begin
                m_loading = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
